// File: rtl/fft_out_pkg.sv
// Shared constants and the default-width buffer entry layout for the FFT output framer.
package fft_out_pkg;

    localparam int FFT_POINTS     = 64;
    localparam int DEF_FFT_NUM    = $clog2(FFT_POINTS);
    localparam int DEF_DATA_WIDTH = 17;
    localparam int DEF_POW_WIDTH  = 2 * DEF_DATA_WIDTH + 1;

    // Field order matches the packed vector the framer writes into its FIFO.
    typedef struct packed {
        logic                             sof;
        logic                             eof;
        logic [DEF_FFT_NUM-1:0]           bin;
        logic signed [DEF_DATA_WIDTH-1:0] re;
        logic signed [DEF_DATA_WIDTH-1:0] im;
        logic [DEF_POW_WIDTH-1:0]         pow;
    } fifo_entry_t;

endpackage

// File: rtl/fft_out_fifo.sv
// Synchronous FIFO with occupancy level; a push while full is accepted only alongside a pop.
module fft_out_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/fft_out_framer.sv
// Tags FFT bins with index/frame markers, computes bin power, and buffers words
// for a valid/ready consumer with a sticky drop flag and delivered-frame counter.
module fft_out_framer
    import fft_out_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FFT_NUM    = DEF_FFT_NUM,
    parameter int FIFO_DEPTH = 16,
    parameter int POW_WIDTH  = 2 * DATA_WIDTH + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] in_re,
    input  logic signed [DATA_WIDTH-1:0] in_im,
    input  logic                         in_valid,
    input  logic                         sync_clr,
    output logic signed [DATA_WIDTH-1:0] out_re,
    output logic signed [DATA_WIDTH-1:0] out_im,
    output logic [POW_WIDTH-1:0]         out_pow,
    output logic [FFT_NUM-1:0]           out_bin,
    output logic                         out_sof,
    output logic                         out_eof,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         overflow,
    input  logic                         clr_ovf,
    output logic [15:0]                  frame_cnt
);

    localparam int SQ_W    = 2 * DATA_WIDTH;
    localparam int ENTRY_W = 2 + FFT_NUM + 2 * DATA_WIDTH + POW_WIDTH;
    localparam int LW      = $clog2(FIFO_DEPTH) + 1;

    logic [FFT_NUM-1:0]           bin_cnt;
    logic [FFT_NUM-1:0]           tag_bin;

    logic                         s1_valid, s1_sof, s1_eof;
    logic [FFT_NUM-1:0]           s1_bin;
    logic signed [DATA_WIDTH-1:0] s1_re, s1_im;
    logic signed [SQ_W-1:0]       s1_sqr, s1_sqi;

    logic                         s2_valid, s2_sof, s2_eof;
    logic [FFT_NUM-1:0]           s2_bin;
    logic signed [DATA_WIDTH-1:0] s2_re, s2_im;
    logic [POW_WIDTH-1:0]         s2_pow;

    logic [ENTRY_W-1:0]           fifo_wdata, fifo_rdata;
    logic                         fifo_full, fifo_empty, fifo_pop, pop_req, drop;
    logic [LW-1:0]                fifo_level;

    // A sync_clr arriving with a sample tags that sample as bin 0.
    assign tag_bin = sync_clr ? '0 : bin_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_cnt <= '0;
        end else if (in_valid) begin
            bin_cnt <= tag_bin + FFT_NUM'(1);
        end else if (sync_clr) begin
            bin_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
            s1_eof   <= 1'b0;
            s1_bin   <= '0;
            s1_re    <= '0;
            s1_im    <= '0;
            s1_sqr   <= '0;
            s1_sqi   <= '0;
            s2_valid <= 1'b0;
            s2_sof   <= 1'b0;
            s2_eof   <= 1'b0;
            s2_bin   <= '0;
            s2_re    <= '0;
            s2_im    <= '0;
            s2_pow   <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sof <= (tag_bin == '0);
                s1_eof <= (&tag_bin);
                s1_bin <= tag_bin;
                s1_re  <= in_re;
                s1_im  <= in_im;
                s1_sqr <= SQ_W'(in_re) * SQ_W'(in_re);
                s1_sqi <= SQ_W'(in_im) * SQ_W'(in_im);
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sof <= s1_sof;
                s2_eof <= s1_eof;
                s2_bin <= s1_bin;
                s2_re  <= s1_re;
                s2_im  <= s1_im;
                s2_pow <= POW_WIDTH'($unsigned(s1_sqr)) + POW_WIDTH'($unsigned(s1_sqi));
            end
        end
    end

    assign fifo_wdata = {s2_sof, s2_eof, s2_bin, s2_re, s2_im, s2_pow};
    assign pop_req    = !out_valid || out_ready;
    assign fifo_pop   = pop_req && !fifo_empty;
    assign drop       = s2_valid && fifo_full && !fifo_pop;

    fft_out_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s2_valid),
        .wdata (fifo_wdata),
        .pop   (pop_req),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_bin   <= '0;
            out_re    <= '0;
            out_im    <= '0;
            out_pow   <= '0;
        end else if (fifo_pop) begin
            out_valid <= 1'b1;
            {out_sof, out_eof, out_bin, out_re, out_im, out_pow} <= fifo_rdata;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
            if (out_valid && out_ready && out_eof) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    a_level_range: assert property (@(posedge clk) disable iff (rst)
        fifo_level <= LW'(FIFO_DEPTH));

endmodule
